// File: rtl/rotation_mat_arbiter.sv
// Round-robin front end that shares one rotation-matrix unit among four requesters.
// It captures the winner's angles, starts the unit and returns its matrix or a timeout.
module rotation_mat_arbiter #(
  parameter int decimalBits = 8,
  parameter int TIMEOUT     = 31
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [3:0]                        req,
  input  logic [4*(decimalBits+3)-1:0]      req_rot_x,
  input  logic [4*(decimalBits+3)-1:0]      req_rot_y,
  input  logic [4*(decimalBits+3)-1:0]      req_rot_z,
  output logic [3:0]                        ack,
  output logic [decimalBits+2:0]            mat_rot_x,
  output logic [decimalBits+2:0]            mat_rot_y,
  output logic [decimalBits+2:0]            mat_rot_z,
  output logic                              mat_start,
  input  logic                              mat_done,
  input  logic [9*(decimalBits+2)-1:0]      mat_m,
  output logic [9*(decimalBits+2)-1:0]      res_m,
  output logic                              res_valid,
  output logic [1:0]                        res_id,
  output logic                              res_timeout,
  output logic                              busy
);

  localparam int AW = decimalBits + 3;
  localparam int MW = decimalBits + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  // Bit 2 flags a valid pick; bits 1:0 are the first requester at or after ptr.
  function automatic logic [2:0] pick_winner(input logic [3:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [7:0]        timer_q, timer_d;
  logic [1:0]        win_q, win_d;
  logic [AW-1:0]     ang_x_q, ang_x_d;
  logic [AW-1:0]     ang_y_q, ang_y_d;
  logic [AW-1:0]     ang_z_q, ang_z_d;
  logic [3:0]        ack_q, ack_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              rvalid_q, rvalid_d;
  logic              rto_q, rto_d;
  logic [1:0]        rid_q, rid_d;
  logic [9*MW-1:0]   rm_q, rm_d;
  logic [2:0]        grant_s;

  // Next-state and output decode for the IDLE/ISSUE/WAIT sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    win_d    = win_q;
    ang_x_d  = ang_x_q;
    ang_y_d  = ang_y_q;
    ang_z_d  = ang_z_q;
    ack_d    = 4'b0000;
    start_d  = 1'b0;
    rvalid_d = 1'b0;
    rto_d    = rto_q;
    rid_d    = rid_q;
    rm_d     = rm_q;
    grant_s  = pick_winner(req, ptr_q);

    case (state_q)
      ST_IDLE: begin
        if (grant_s[2]) begin
          win_d   = grant_s[1:0];
          ang_x_d = req_rot_x[grant_s[1:0]*AW +: AW];
          ang_y_d = req_rot_y[grant_s[1:0]*AW +: AW];
          ang_z_d = req_rot_z[grant_s[1:0]*AW +: AW];
          ack_d   = 4'b0001 << grant_s[1:0];
          ptr_d   = grant_s[1:0] + 2'd1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        start_d = 1'b1;
        timer_d = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion on the final timer cycle still counts as a real result.
        if (mat_done) begin
          rm_d     = mat_m;
          rid_d    = win_q;
          rto_d    = 1'b0;
          rvalid_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          rm_d     = '0;
          rid_d    = win_q;
          rto_d    = 1'b1;
          rvalid_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          timer_d  = timer_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any job in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'd0;
      timer_q  <= 8'd0;
      win_q    <= 2'd0;
      ang_x_q  <= '0;
      ang_y_q  <= '0;
      ang_z_q  <= '0;
      ack_q    <= 4'b0000;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rto_q    <= 1'b0;
      rid_q    <= 2'd0;
      rm_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      timer_q  <= timer_d;
      win_q    <= win_d;
      ang_x_q  <= ang_x_d;
      ang_y_q  <= ang_y_d;
      ang_z_q  <= ang_z_d;
      ack_q    <= ack_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      rto_q    <= rto_d;
      rid_q    <= rid_d;
      rm_q     <= rm_d;
    end
  end

  assign ack         = ack_q;
  assign mat_rot_x   = ang_x_q;
  assign mat_rot_y   = ang_y_q;
  assign mat_rot_z   = ang_z_q;
  assign mat_start   = start_q;
  assign busy        = busy_q;
  assign res_valid   = rvalid_q;
  assign res_timeout = rto_q;
  assign res_id      = rid_q;
  assign res_m       = rm_q;

endmodule

// File: tb/tb_rotation_mat_arbiter.sv
// Scoreboard bench for rotation_mat_arbiter: the bench plays requesters and the matrix unit,
// queues the expected delivery per job and compares it when res_valid appears.
module tb_rotation_mat_arbiter;

  localparam int DB = 8;
  localparam int TO = 31;
  localparam int AW = DB + 3;
  localparam int MW = DB + 2;

  typedef struct {
    int               id;
    bit               to;
    logic [9*MW-1:0]  m;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [3:0]        req;
  logic [4*AW-1:0]   req_rot_x, req_rot_y, req_rot_z;
  logic [3:0]        ack;
  logic [AW-1:0]     mat_rot_x, mat_rot_y, mat_rot_z;
  logic              mat_start;
  logic              mat_done;
  logic [9*MW-1:0]   mat_m;
  logic [9*MW-1:0]   res_m;
  logic              res_valid;
  logic [1:0]        res_id;
  logic              res_timeout;
  logic              busy;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  rotation_mat_arbiter #(.decimalBits(DB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_rot_x(req_rot_x), .req_rot_y(req_rot_y), .req_rot_z(req_rot_z),
    .ack(ack), .mat_rot_x(mat_rot_x), .mat_rot_y(mat_rot_y), .mat_rot_z(mat_rot_z),
    .mat_start(mat_start), .mat_done(mat_done), .mat_m(mat_m),
    .res_m(res_m), .res_valid(res_valid), .res_id(res_id),
    .res_timeout(res_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] ang_x(input int i);
    return AW'(64 + 8 * i);
  endfunction
  function automatic logic [AW-1:0] ang_y(input int i);
    return AW'(-5 * i);
  endfunction
  function automatic logic [AW-1:0] ang_z(input int i);
    return AW'(7 * i);
  endfunction

  function automatic logic [9*MW-1:0] mk_pat(input int seed);
    logic [9*MW-1:0] p;
    for (int j = 0; j < 9; j++) p[j*MW +: MW] = MW'(seed * 37 + j * 11 + 1);
    return p;
  endfunction

  // Scoreboard side: every delivery must match the oldest queued expectation.
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_res_valid", 128'(res_valid), 128'(0));
      end else begin
        mon_e = sb_q.pop_front();
        check("res_id", 128'(res_id), 128'(mon_e.id));
        check("res_timeout", 128'(res_timeout), 128'(mon_e.to));
        check("res_m", 128'(res_m), 128'(mon_e.m));
      end
    end
  end

  // One job: raise mask, expect grant exp_id, answer after lat WAIT cycles (lat<0: never).
  task automatic run_job(input logic [3:0] mask, input int exp_id, input int lat,
                         input logic [9*MW-1:0] pat, input logic [3:0] blip);
    int   k;
    bit   to;
    logic [3:0] rest;
    exp_t e;
    to   = (lat < 0) || (lat > TO - 1);
    e.id = exp_id;
    e.to = to;
    e.m  = to ? '0 : pat;
    sb_q.push_back(e);
    rest = mask & ~(4'b0001 << exp_id);
    req  = mask;
    @(negedge clk);
    check("ack", 128'(ack), 128'(4'b0001 << exp_id));
    check("busy_issue", 128'(busy), 128'(1));
    check("mat_rot_x", 128'(mat_rot_x), 128'(ang_x(exp_id)));
    check("mat_rot_y", 128'(mat_rot_y), 128'(ang_y(exp_id)));
    check("mat_rot_z", 128'(mat_rot_z), 128'(ang_z(exp_id)));
    req = rest;
    @(negedge clk);
    check("mat_start", 128'(mat_start), 128'(1));
    k = 0;
    while (res_valid !== 1'b1 && k <= TO + 4) begin
      if (k == 1) check("mat_start_pulse", 128'({mat_start, ack}), 128'(0));
      req      = (k >= 2 && k < 5) ? (rest | blip) : rest;
      mat_done = (k == lat);
      mat_m    = (k == lat) ? pat : ~pat;
      @(negedge clk);
      k++;
    end
    mat_done = 1'b0;
    req      = rest;
    check("latency", 128'(k), 128'(to ? TO : lat + 1));
    check("busy_after", 128'(busy), 128'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 128'({ack, mat_start, res_valid, res_id, res_timeout, busy}), 128'(0));
    check({tag, "_rot"}, 128'({mat_rot_x, mat_rot_y, mat_rot_z}), 128'(0));
    check({tag, "_res_m"}, 128'(res_m), 128'(0));
  endtask

  initial begin
    reset    = 1'b0;
    req      = 4'b0000;
    mat_done = 1'b0;
    mat_m    = '0;
    for (int i = 0; i < 4; i++) begin
      req_rot_x[i*AW +: AW] = ang_x(i);
      req_rot_y[i*AW +: AW] = ang_y(i);
      req_rot_z[i*AW +: AW] = ang_z(i);
    end
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Basic single request, 18-cycle matrix latency.
    run_job(4'b0001, 0, 18, mk_pat(1), 4'b0000);

    // Fresh pointer, all four requesting: strict rotation with wrap.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 5; n++) run_job(4'b1111, n % 4, 2 + n, mk_pat(10 + n), 4'b0000);

    // No answer: timeout; a request raised and dropped mid-job must never be granted.
    run_job(4'b0100, 2, -1, mk_pat(20), 4'b0010);
    req = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      check("dropped_req_no_ack", 128'({ack, busy}), 128'(0));
    end

    // Completion on the last timer cycle wins over the timeout.
    run_job(4'b1000, 3, TO - 1, mk_pat(21), 4'b0000);
    // Zero latency, then the pending request that waited is served.
    run_job(4'b0011, 0, 0, mk_pat(22), 4'b0000);
    run_job(4'b0011, 1, 1, mk_pat(23), 4'b0000);

    // Stray completion while idle changes nothing.
    req      = 4'b0000;
    mat_done = 1'b1;
    mat_m    = mk_pat(30);
    @(negedge clk);
    mat_done = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_done_res_m", 128'(res_m), 128'(mk_pat(23)));
    check("idle_done_res", 128'({res_id, res_timeout, busy, ack}), 128'({2'd1, 1'b0, 1'b0, 4'b0000}));

    // Reset in the middle of WAIT abandons the job; later stray done is ignored.
    req = 4'b0010;
    @(negedge clk);
    check("ack_pre_reset", 128'(ack), 128'(4'b0010));
    req = 4'b0000;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("mid_wait_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    mat_done = 1'b1;
    mat_m    = mk_pat(31);
    @(negedge clk);
    mat_done = 1'b0;
    repeat (TO + 5) @(negedge clk);
    check_all_zero("after_reset_done");

    // Recovery: pointer back at 0 after reset.
    run_job(4'b1001, 0, 5, mk_pat(40), 4'b0000);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    check("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
